// File: rtl/ysyx_24080006_csr_pkg.sv
// Shared constants for the machine-mode CSR/trap block: CSR addresses, op encoding,
// mstatus field positions and reset values.
package ysyx_24080006_csr_pkg;

    localparam int unsigned CSR_ADDR_W = 12;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
    localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID   = 12'hF12;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam logic [31:0] MSTATUS_RESET  = 32'h0000_1800;
    localparam logic [1:0]  MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/ysyx_24080006_csr_trap_if.sv
// WBU <-> CSR/trap block bundle: CSR access, trap/mret events and the IFU redirect.
interface ysyx_24080006_csr_trap_if #(
    parameter int unsigned XLEN = 32
);
    import ysyx_24080006_csr_pkg::*;

    logic                  csr_valid;
    csr_op_e               csr_op;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]       csr_wdata;
    logic [XLEN-1:0]       csr_rdata;
    logic                  csr_illegal;
    logic                  trap_valid;
    logic [XLEN-1:0]       trap_cause;
    logic [XLEN-1:0]       trap_pc;
    logic [XLEN-1:0]       trap_tval;
    logic                  mret_valid;
    logic                  instret;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;

    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata,
        output trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, instret,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );

    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata,
        input  trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, instret,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ysyx_24080006_csr_counter64.sv
// 64-bit event counter with independently writable 32-bit halves; any write
// suppresses the increment for that cycle.
module ysyx_24080006_csr_counter64 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [63:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (we_lo || we_hi) begin
            if (we_lo) cnt_q[31:0]  <= wdata_lo;
            if (we_hi) cnt_q[63:32] <= wdata_hi;
        end else begin
            cnt_q <= cnt_q + 64'(inc);
        end
    end

    assign lo = cnt_q[31:0];
    assign hi = cnt_q[63:32];

endmodule

// File: rtl/ysyx_24080006_csr_trap.sv
// Machine-mode CSR file with trap entry/mret sequencing and a registered PC
// redirect to the IFU. Priority within a cycle: trap > mret > CSR write.
module ysyx_24080006_csr_trap
    import ysyx_24080006_csr_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] MVENDORID    = 32'h7973_7978,
    parameter logic [31:0] MARCHID      = 32'd24080006,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input logic                    clock,
    input logic                    reset_n,
    ysyx_24080006_csr_trap_if.slave bus
);

    localparam bit IS32 = (XLEN == 32);
    // On RV64 the full counter lives at the low address, so both halves are written there.
    localparam logic [CSR_ADDR_W-1:0] CYC_HI_ADDR = IS32 ? CSR_MCYCLEH   : CSR_MCYCLE;
    localparam logic [CSR_ADDR_W-1:0] INS_HI_ADDR = IS32 ? CSR_MINSTRETH : CSR_MINSTRET;

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [63:0]     mcycle, minstret;

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] csr_old;
    logic            csr_impl;
    logic            csr_writes;
    logic            csr_illegal;
    logic            csr_we;
    logic [XLEN-1:0] csr_wval;
    logic [63:0]     wval64;
    logic [31:0]     cnt_wdata_hi;
    logic            cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    always_comb begin
        mstatus_rd               = XLEN'(MSTATUS_RESET);
        mstatus_rd[MSTATUS_MIE]  = mie_q;
        mstatus_rd[MSTATUS_MPIE] = mpie_q;
    end

    // Address decode and current value of the addressed CSR.
    always_comb begin
        csr_old  = '0;
        csr_impl = 1'b0;
        case (bus.csr_addr)
            CSR_MSTATUS:   begin csr_impl = 1'b1; csr_old = mstatus_rd; end
            CSR_MTVEC:     begin csr_impl = 1'b1; csr_old = mtvec_q; end
            CSR_MSCRATCH:  begin csr_impl = 1'b1; csr_old = mscratch_q; end
            CSR_MEPC:      begin csr_impl = 1'b1; csr_old = mepc_q; end
            CSR_MCAUSE:    begin csr_impl = 1'b1; csr_old = mcause_q; end
            CSR_MTVAL:     begin csr_impl = 1'b1; csr_old = mtval_q; end
            CSR_MVENDORID: begin csr_impl = 1'b1; csr_old = XLEN'(MVENDORID); end
            CSR_MARCHID:   begin csr_impl = 1'b1; csr_old = XLEN'(MARCHID); end
            CSR_MCYCLE:    begin csr_impl = HAS_COUNTERS; csr_old = XLEN'(mcycle); end
            CSR_MINSTRET:  begin csr_impl = HAS_COUNTERS; csr_old = XLEN'(minstret); end
            CSR_MCYCLEH:   begin csr_impl = HAS_COUNTERS && IS32; csr_old = XLEN'(mcycle[63:32]); end
            CSR_MINSTRETH: begin csr_impl = HAS_COUNTERS && IS32; csr_old = XLEN'(minstret[63:32]); end
            default:       begin csr_impl = 1'b0; csr_old = '0; end
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it is legal on read-only CSRs.
    assign csr_writes  = (bus.csr_op == CSR_RW) ||
                         (((bus.csr_op == CSR_RS) || (bus.csr_op == CSR_RC)) && (bus.csr_wdata != '0));
    assign csr_illegal = bus.csr_valid &&
                         (!csr_impl || ((bus.csr_addr[11:10] == 2'b11) && csr_writes));
    assign csr_we      = bus.csr_valid && !csr_illegal && csr_writes &&
                         !bus.trap_valid && !bus.mret_valid;

    always_comb begin
        case (bus.csr_op)
            CSR_RS:  csr_wval = csr_old | bus.csr_wdata;
            CSR_RC:  csr_wval = csr_old & ~bus.csr_wdata;
            default: csr_wval = bus.csr_wdata;
        endcase
    end

    assign bus.csr_rdata   = (csr_illegal || !csr_impl) ? '0 : csr_old;
    assign bus.csr_illegal = csr_illegal;

    always_comb begin
        trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
        trap_target = trap_base;
        if ((mtvec_q[1:0] == MTVEC_VECTORED) && bus.trap_cause[XLEN-1])
            trap_target = trap_base + {bus.trap_cause[XLEN-3:0], 2'b00};
    end

    assign wval64       = 64'(csr_wval);
    assign cnt_wdata_hi = IS32 ? wval64[31:0] : wval64[63:32];
    assign cyc_we_lo    = csr_we && (bus.csr_addr == CSR_MCYCLE);
    assign cyc_we_hi    = csr_we && (bus.csr_addr == CYC_HI_ADDR);
    assign ins_we_lo    = csr_we && (bus.csr_addr == CSR_MINSTRET);
    assign ins_we_hi    = csr_we && (bus.csr_addr == INS_HI_ADDR);

    if (HAS_COUNTERS) begin : g_counters
        ysyx_24080006_csr_counter64 u_mcycle (
            .clock    (clock),
            .reset_n  (reset_n),
            .inc      (1'b1),
            .we_lo    (cyc_we_lo),
            .we_hi    (cyc_we_hi),
            .wdata_lo (wval64[31:0]),
            .wdata_hi (cnt_wdata_hi),
            .lo       (mcycle[31:0]),
            .hi       (mcycle[63:32])
        );

        ysyx_24080006_csr_counter64 u_minstret (
            .clock    (clock),
            .reset_n  (reset_n),
            .inc      (bus.instret),
            .we_lo    (ins_we_lo),
            .we_hi    (ins_we_hi),
            .wdata_lo (wval64[31:0]),
            .wdata_hi (cnt_wdata_hi),
            .lo       (minstret[31:0]),
            .hi       (minstret[63:32])
        );
    end else begin : g_no_counters
        assign mcycle   = '0;
        assign minstret = '0;
    end

    // Architectural state and redirect register; lower-priority actions are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mie_q            <= 1'b0;
            mpie_q           <= 1'b0;
            mtvec_q          <= '0;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (bus.trap_valid) begin
                mepc_q           <= {bus.trap_pc[XLEN-1:2], 2'b00};
                mcause_q         <= bus.trap_cause;
                mtval_q          <= bus.trap_tval;
                mpie_q           <= mie_q;
                mie_q            <= 1'b0;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= trap_target;
            end else if (bus.mret_valid) begin
                mie_q            <= mpie_q;
                mpie_q           <= 1'b1;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= mepc_q;
            end else if (csr_we) begin
                case (bus.csr_addr)
                    CSR_MSTATUS: begin
                        mie_q  <= csr_wval[MSTATUS_MIE];
                        mpie_q <= csr_wval[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:    mtvec_q    <= {csr_wval[XLEN-1:2], csr_wval[1] ? 2'b00 : csr_wval[1:0]};
                    CSR_MSCRATCH: mscratch_q <= csr_wval;
                    CSR_MEPC:     mepc_q     <= {csr_wval[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= csr_wval;
                    CSR_MTVAL:    mtval_q    <= csr_wval;
                    default: ;
                endcase
            end
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: doc/ysyx_24080006_csr_trap.md
Name: ysyx_24080006_csr_trap

Overview:
Machine-mode CSR file with built-in trap sequencing, placed in the WBU. It succeeds the fixed 8-entry CSR array. Additions:
- width parametrisation
- read-modify-write CSR ops
- illegal-access detection
- hardware trap entry and mret
- 64-bit mcycle/minstret counters
- a registered PC redirect to the IFU

Parameters:
XLEN, 32, data width; legal values 32 or 64.
MVENDORID, 32'h79737978, read-only mvendorid value.
MARCHID, 32'd24080006, read-only marchid value.
HAS_COUNTERS, 1, 1 instantiates mcycle/minstret (and the h-halves when XLEN=32); 0 makes those addresses illegal.

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
csr_valid  in  1  CSR instruction retiring this cycle
csr_op  in  2  01 RW, 10 RS (set bits), 11 RC (clear bits), 00 reserved (treated as no write)
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  rs1/zimm operand
csr_rdata  out  XLEN  old CSR value, combinational
csr_illegal  out  1  combinational illegal-access flag
trap_valid  in  1  exception/interrupt taken this cycle
trap_cause  in  XLEN  mcause value; MSB = interrupt
trap_pc  in  XLEN  faulting PC
trap_tval  in  XLEN  mtval value
mret_valid  in  1  mret retiring
instret  in  1  one instruction retired
redirect_valid  out  1  one-cycle pulse: fetch from redirect_pc
redirect_pc  out  XLEN  target PC

Behaviour:
- Reset (async on negedge of reset_n, released synchronously by design):
  - mstatus = 0x1800 (MPP=11, MIE=0, MPIE=0)
  - mtvec, mepc, mcause, mtval, mscratch, mcycle, minstret = 0
  - redirect_valid = 0, redirect_pc = 0
- Implemented CSRs:
  - 0x300 mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] reads 11.
  - 0x305 mtvec: [1:0] mode (00 direct, 01 vectored; 1x written as 00).
  - 0x340 mscratch.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0xB00/0xB80 mcycle/mcycleh.
  - 0xB02/0xB82 minstret/minstreth.
  - 0xF11 mvendorid, 0xF12 marchid: read-only.
  - The h-halves exist only when XLEN=32.
- Read: csr_rdata = current value of the addressed CSR; 0 when the address is illegal.
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- The update commits at the next clock edge when csr_valid=1 and csr_illegal=0.
- RS/RC with wdata=0 perform no write: no side effects, and they are legal on read-only CSRs.
- csr_illegal=1 when csr_valid=1 and either:
  - the address is unimplemented, or
  - the address has [11:10]=11 and the op writes (RW always; RS/RC with wdata≠0).
- An illegal access updates nothing.
- Trap entry (trap_valid=1), applied at the next edge:
  - mepc ← trap_pc & ~3
  - mcause ← trap_cause
  - mtval ← trap_tval
  - MPIE ← MIE, MIE ← 0
- Trap target:
  - Direct mode, or trap_cause MSB=0: target = {mtvec[XLEN-1:2], 00}.
  - Vectored mode with trap_cause MSB=1: target = base + 4×cause[XLEN-2:0], truncated to XLEN.
- mret (mret_valid=1): MIE ← MPIE, MPIE ← 1; target = mepc.
- Redirect: registered, one-cycle latency. redirect_valid is high exactly one cycle after the trap/mret cycle, with redirect_pc holding the target. Otherwise redirect_valid=0 and redirect_pc holds its last value.
- Priority in the same cycle: trap > mret > CSR write.
  - The lower-priority action is dropped entirely.
  - csr_rdata and csr_illegal are still driven from the combinational decode.
- Counters:
  - mcycle += 1 every cycle out of reset.
  - minstret += instret.
  - Both are 64-bit and wrap from 2^64−1 to 0.
  - A committed CSR write to either half replaces that half and suppresses that counter's increment for that cycle; the other half is unchanged.
- Reset asserted mid-operation clears a pending redirect immediately (redirect_valid → 0 asynchronously).

Decomposition:
- Package ysyx_24080006_csr_pkg holds:
  - CSR address localparams
  - csr_op enum (CSR_NONE/RW/RS/RC)
  - mstatus bit positions
  - the reset value 0x1800
- One sub-module, ysyx_24080006_csr_counter64, contains:
  - 64-bit counter with inc input
  - per-half write enable and write data
  - lo/hi outputs
  - asynchronous active-low reset
- It is instantiated twice: mcycle and minstret.

Test Plan:
- Reset release, read 0x300/0xF11/0xF12 → 0x1800, 0x79737978, 24080006; redirect_valid=0.
- RW 0x305 ← 0x80000001, trap cause=0x80000007, pc=0x80000104 → next cycle redirect_valid=1, redirect_pc=0x8000001C; mepc=0x80000104, MIE=0, MPIE=old MIE.
- mstatus RS 0x8 (MIE=1), trap cause=2, then mret → first redirect = mtvec base; after mret MIE=1, MPIE=1, redirect_pc=mepc.
- RW to 0xF11 → csr_illegal=1, value unchanged. RS 0xF11 with wdata=0 → csr_illegal=0, rdata=0x79737978. Access 0x7C0 → csr_illegal=1, rdata=0.
- RW mcycle ← 0xFFFFFFFF with mcycleh=0, two idle cycles → mcycle=0x00000001, mcycleh=1. minstret counts exactly 5 for 5 instret pulses.
- trap_valid, mret_valid and csr_valid (RW mscratch ← 5) all high in one cycle → only the trap applies; mscratch unchanged; redirect to mtvec. Then reset_n low mid-redirect → redirect_valid=0 immediately.
